// File: rtl/sparse_block_scheduler_pkg.sv
// Shared definitions for the sparse block scheduler: FSM state encoding and
// the array-geometry constants used for draining and activation skew.
package sparse_block_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    STREAM,
    DRAIN,
    GAP,
    FIN
  } sched_state_e;

  // Cycles of zero injection needed to flush the last vector through the array.
  function automatic int unsigned drain_len(input int unsigned n_rows,
                                            input int unsigned n_cols);
    return n_rows + n_cols - 2;
  endfunction

  // Delay, in cycles, applied to activation lane 'lane' before the array.
  function automatic int unsigned skew_depth(input int unsigned lane);
    return lane + 1;
  endfunction

endpackage

// File: rtl/sparse_block_scheduler_act_skew.sv
// Per-lane activation delay lines: lane r is delayed skew_depth(r) cycles.
module act_skew_line
  import sparse_block_scheduler_pkg::*;
#(
  parameter int unsigned N_ROWS = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_ROWS*DATA_W-1:0] in_flat,
  output logic [N_ROWS*DATA_W-1:0] out_flat
);

  for (genvar r = 0; r < N_ROWS; r++) begin : g_lane
    localparam int unsigned DEPTH = skew_depth(r);

    logic [DATA_W-1:0] sr_q [DEPTH];
    logic [DATA_W-1:0] sr_d [DEPTH];

    // Shift the lane by one stage per cycle.
    always_comb begin
      sr_d[0] = in_flat[r*DATA_W +: DATA_W];
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end

    // Stage registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          sr_q[i] <= '0;
        end
      end else begin
        sr_q <= sr_d;
      end
    end

    assign out_flat[r*DATA_W +: DATA_W] = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/sparse_block_scheduler.sv
// Sparse block scheduler: fetches block descriptors, skips zero blocks, and
// sequences weight load, skewed activation streaming and array drain.
module sparse_block_scheduler
  import sparse_block_scheduler_pkg::*;
#(
  parameter int unsigned N_ROWS = 16,
  parameter int unsigned N_COLS = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [15:0]              cfg_num_blocks,
  input  logic [15:0]              cfg_k_len,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic                     desc_nonzero,
  input  logic [AW-1:0]            desc_wgt_base,
  input  logic [AW-1:0]            desc_act_base,
  output logic                     wgt_rd_en,
  output logic [AW-1:0]            wgt_rd_addr,
  input  logic [N_COLS*DATA_W-1:0] wgt_rd_data,
  output logic                     act_rd_en,
  output logic [AW-1:0]            act_rd_addr,
  input  logic [N_ROWS*DATA_W-1:0] act_rd_data,
  output logic                     load_weight,
  output logic                     block_valid,
  output logic [N_COLS*DATA_W-1:0] b_out_flat,
  output logic [N_ROWS*DATA_W-1:0] a_out_flat,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              skipped_count
);

  localparam int unsigned DRAIN_LEN  = drain_len(N_ROWS, N_COLS);
  localparam logic [15:0] LOAD_LAST  = 16'(N_ROWS - 1);
  // block_valid lags the FSM by one cycle, so the DRAIN state holds one extra
  // cycle to give the array DRAIN_LEN drain cycles before the GAP low cycle.
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_LEN);

  sched_state_e      state_q, state_d;
  logic [15:0]       blocks_left_q, blocks_left_d;
  logic [15:0]       k_len_q, k_len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       skipped_q, skipped_d;
  logic [AW-1:0]     wgt_addr_q, wgt_addr_d;
  logic [AW-1:0]     act_addr_q, act_addr_d;
  logic              load_weight_q, load_weight_d;
  logic              block_valid_q, block_valid_d;
  logic              act_vld_q, act_vld_d;

  logic [N_ROWS*DATA_W-1:0] skew_in;

  // Next-state and counter logic for the job sequencer.
  always_comb begin
    state_d       = state_q;
    blocks_left_d = blocks_left_q;
    k_len_d       = k_len_q;
    cnt_d         = cnt_q;
    skipped_d     = skipped_q;
    wgt_addr_d    = wgt_addr_q;
    act_addr_d    = act_addr_q;
    load_weight_d = (state_q == LOAD);
    block_valid_d = (state_q == STREAM) || ((state_q == DRAIN) && (cnt_q != DRAIN_LAST));
    act_vld_d     = (state_q == STREAM);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          skipped_d     = '0;
          blocks_left_d = cfg_num_blocks;
          k_len_d       = cfg_k_len;
          cnt_d         = '0;
          state_d       = (cfg_num_blocks == 16'd0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        if (desc_valid) begin
          blocks_left_d = blocks_left_q - 16'd1;
          if (!desc_nonzero || (k_len_q == 16'd0)) begin
            skipped_d = skipped_q + 16'd1;
            state_d   = (blocks_left_q == 16'd1) ? FIN : FETCH;
          end else begin
            wgt_addr_d = desc_wgt_base;
            act_addr_d = desc_act_base;
            cnt_d      = '0;
            state_d    = LOAD;
          end
        end
      end
      LOAD: begin
        wgt_addr_d = wgt_addr_q + AW'(1);
        cnt_d      = cnt_q + 16'd1;
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        act_addr_d = act_addr_q + AW'(1);
        cnt_d      = cnt_q + 16'd1;
        if (cnt_q == k_len_q - 16'd1) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP:     state_d = (blocks_left_q == 16'd0) ? FIN : FETCH;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      blocks_left_q <= '0;
      k_len_q       <= '0;
      cnt_q         <= '0;
      skipped_q     <= '0;
      wgt_addr_q    <= '0;
      act_addr_q    <= '0;
      load_weight_q <= 1'b0;
      block_valid_q <= 1'b0;
      act_vld_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      blocks_left_q <= blocks_left_d;
      k_len_q       <= k_len_d;
      cnt_q         <= cnt_d;
      skipped_q     <= skipped_d;
      wgt_addr_q    <= wgt_addr_d;
      act_addr_q    <= act_addr_d;
      load_weight_q <= load_weight_d;
      block_valid_q <= block_valid_d;
      act_vld_q     <= act_vld_d;
    end
  end

  assign desc_ready    = (state_q == FETCH);
  assign wgt_rd_en     = (state_q == LOAD);
  assign act_rd_en     = (state_q == STREAM);
  assign wgt_rd_addr   = wgt_addr_q;
  assign act_rd_addr   = act_addr_q;
  assign load_weight   = load_weight_q;
  assign block_valid   = block_valid_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
  assign skipped_count = skipped_q;
  assign b_out_flat    = load_weight_q ? wgt_rd_data : '0;
  assign skew_in       = act_vld_q ? act_rd_data : '0;

  act_skew_line #(
    .N_ROWS (N_ROWS),
    .DATA_W (DATA_W)
  ) u_act_skew (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_flat  (skew_in),
    .out_flat (a_out_flat)
  );

endmodule
